// File: rtl/obi_mem_model_mp_if.sv
// Per-port req/gnt/rvalid bundle for the multi-port memory model, packed port-major.
// Latency: none, wires only.
// Backpressure: requests wait for gnt; responses cannot be stalled.
interface obi_mem_model_mp_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]    req_i;
    logic [NPORTS-1:0]    we_i;
    logic [4*NPORTS-1:0]  be_i;
    logic [32*NPORTS-1:0] addr_i;
    logic [32*NPORTS-1:0] wdata_i;
    logic [NPORTS-1:0]    gnt_o;
    logic [NPORTS-1:0]    rvalid_o;
    logic [32*NPORTS-1:0] rdata_o;
    logic [NPORTS-1:0]    err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_mem_model_mp.sv
// Multi-port word memory model: NPORTS req/gnt/rvalid channels over one shared array.
// Latency: response RD_LATENCY cycles after the accept edge (RD_LATENCY=1 -> next cycle).
// Backpressure: LFSR-driven grant stalls per port; response path has no backpressure.
module obi_mem_model_mp #(
    parameter int          NPORTS      = 2,
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LATENCY  = 1,
    parameter logic [7:0]  STALL_MASK  = 8'h00,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic               clk_i,
    input logic               rst_ni,
    obi_mem_model_mp_if.slave bus
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);
    localparam logic [31:0] OOR_RDATA = 32'hBADC_AB1E;

    // Storage and per-port state
    logic [31:0]           r_mem  [DEPTH_WORDS];
    logic [15:0]           r_lfsr [NPORTS];
    logic [RD_LATENCY-1:0] r_vld  [NPORTS];
    logic [RD_LATENCY-1:0] r_err  [NPORTS];
    logic [31:0]           r_dat  [NPORTS][RD_LATENCY];

    // Per-port decode
    logic [NPORTS-1:0]     w_stall;
    logic [NPORTS-1:0]     w_gnt;
    logic [NPORTS-1:0]     w_acc;
    logic [NPORTS-1:0]     w_wr;
    logic [NPORTS-1:0]     w_inr;
    logic [32:0]           w_diff    [NPORTS];
    logic [AW-1:0]         w_idx     [NPORTS];
    logic [31:0]           w_rsp_dat [NPORTS];
    logic [2*NPORTS-1:0]   w_unused_addr_lsb;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        // Borrow out of (addr - BASE_ADDR) means the address sits below the window
        assign w_diff[g] = {1'b0, bus.addr_i[32*g +: 32]} - {1'b0, BASE_ADDR};
        assign w_inr[g]  = !w_diff[g][32] && ({2'b00, w_diff[g][31:2]} < DEPTH_W);
        assign w_idx[g]  = w_diff[g][AW+1:2];
        assign w_unused_addr_lsb[2*g +: 2] = w_diff[g][1:0];

        // Grant never looks at address/data: only req, the stall LFSR and reset
        assign w_stall[g] = (STALL_MASK != 8'h00) && ((r_lfsr[g][7:0] & STALL_MASK) == 8'h00);
        assign w_gnt[g]   = bus.req_i[g] & ~w_stall[g] & rst_ni;
        assign w_acc[g]   = bus.req_i[g] & w_gnt[g];
        assign w_wr[g]    = w_acc[g] & bus.we_i[g] & w_inr[g];

        // Array read is combinational, so it sees contents before this edge's writes
        assign w_rsp_dat[g] = !w_inr[g]      ? OOR_RDATA :
                              bus.we_i[g]    ? 32'h0     :
                                               r_mem[w_idx[g]];

        assign bus.gnt_o[g]             = w_gnt[g];
        assign bus.rvalid_o[g]          = r_vld[g][RD_LATENCY-1];
        assign bus.err_o[g]             = r_err[g][RD_LATENCY-1];
        assign bus.rdata_o[32*g +: 32]  = r_dat[g][RD_LATENCY-1];
    end

    // Stall LFSRs: reload port-specific seed on reset, otherwise advance every cycle
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (!rst_ni) begin
                r_lfsr[p] <= LFSR_SEED ^ 16'(p);
            end else begin
                r_lfsr[p] <= {r_lfsr[p][14:0],
                              r_lfsr[p][15] ^ r_lfsr[p][13] ^ r_lfsr[p][12] ^ r_lfsr[p][10]};
            end
        end
    end

    // Byte-enabled writes; ascending port order lets the highest port win each byte
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NPORTS; p++) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr[p] && bus.be_i[4*p + b]) begin
                    r_mem[w_idx[p]][8*b +: 8] <= bus.wdata_i[32*p + 8*b +: 8];
                end
            end
        end
    end

    // Response shift registers; empty slots carry zero data so outputs idle at 0
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (!rst_ni) begin
                r_vld[p] <= '0;
                r_err[p] <= '0;
                for (int s = 0; s < RD_LATENCY; s++) begin
                    r_dat[p][s] <= 32'h0;
                end
            end else begin
                r_vld[p][0] <= w_acc[p];
                r_err[p][0] <= w_acc[p] & ~w_inr[p];
                r_dat[p][0] <= w_acc[p] ? w_rsp_dat[p] : 32'h0;
                for (int s = 1; s < RD_LATENCY; s++) begin
                    r_vld[p][s] <= r_vld[p][s-1];
                    r_err[p][s] <= r_err[p][s-1];
                    r_dat[p][s] <= r_dat[p][s-1];
                end
            end
        end
    end
endmodule
